// File: rtl/writeback_arbiter_if.sv
// rtl/writeback_arbiter_if.sv - result source handshake and register-file write port bundle
interface writeback_arbiter_if #(
    parameter int NUM_SRC   = 4,
    parameter int DATA_BITS = 16
);
    logic [NUM_SRC-1:0]           src_valid;
    logic [NUM_SRC*4-1:0]         src_rd;
    logic [NUM_SRC*DATA_BITS-1:0] src_data;
    logic [NUM_SRC-1:0]           src_ready;
    logic                         wb_valid;
    logic [3:0]                   wb_rd;
    logic [DATA_BITS-1:0]         wb_data;

    // Result units and register file side
    modport master (
        output src_valid, src_rd, src_data,
        input  src_ready, wb_valid, wb_rd, wb_data
    );

    // Arbiter side
    modport slave (
        input  src_valid, src_rd, src_data,
        output src_ready, wb_valid, wb_rd, wb_data
    );
endinterface

// File: rtl/writeback_arbiter.sv
// rtl/writeback_arbiter.sv - round-robin result write-back arbiter with busy-register scoreboard
module writeback_arbiter #(
    parameter int NUM_SRC   = 4,
    parameter int DATA_BITS = 16,
    parameter int NUM_FREE  = 13
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    writeback_arbiter_if.slave   bus,
    input  logic                 issue_valid,
    input  logic [3:0]           issue_rd,
    input  logic [3:0]           chk_rs,
    input  logic [3:0]           chk_rt,
    input  logic [3:0]           chk_rd,
    output logic                 hazard,
    output logic [15:0]          busy,
    output logic                 idle,
    output logic                 wb_err
);
    localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam logic [4:0]  FREE_LIM = 5'(NUM_FREE);
    localparam logic [15:0] WR_MASK  = 16'((32'd1 << NUM_FREE) - 32'd1);

    logic [PTR_W-1:0]     rr_ptr;
    logic [PTR_W-1:0]     cand;
    logic [PTR_W-1:0]     grant_idx;
    logic [PTR_W-1:0]     rr_next;
    logic                 grant_any;
    logic [NUM_SRC-1:0]   grant;
    logic [3:0]           grant_rd;
    logic [DATA_BITS-1:0] grant_data;
    logic                 grant_writable;
    logic                 issue_writable;
    logic [15:0]          busy_next;

    // Round-robin search for the first valid source at or after rr_ptr
    always_comb begin
        cand      = '0;
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            cand = PTR_W'((int'(rr_ptr) + k) % NUM_SRC);
            if (enable && !grant_any && bus.src_valid[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
        grant[grant_idx] = grant_any;
    end

    assign bus.src_ready   = grant;
    assign grant_rd        = bus.src_rd[4*grant_idx +: 4];
    assign grant_data      = bus.src_data[DATA_BITS*grant_idx +: DATA_BITS];
    assign grant_writable  = ({1'b0, grant_rd} < FREE_LIM);
    assign issue_writable  = ({1'b0, issue_rd} < FREE_LIM);
    assign rr_next         = PTR_W'((int'(grant_idx) + 1) % NUM_SRC);

    // Scoreboard update: completing write clears, new issue sets; set applied last so it wins
    always_comb begin
        busy_next = busy;
        if (grant_any && grant_writable)
            busy_next[grant_rd] = 1'b0;
        if (enable && issue_valid && issue_writable)
            busy_next[issue_rd] = 1'b1;
        busy_next = busy_next & WR_MASK;
    end

    // Registered write port, pointer, scoreboard and sticky error
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.wb_valid <= 1'b0;
            bus.wb_rd    <= '0;
            bus.wb_data  <= '0;
            busy         <= '0;
            wb_err       <= 1'b0;
            rr_ptr       <= '0;
        end else if (enable) begin
            bus.wb_valid <= grant_any && grant_writable;
            busy         <= busy_next;
            if (grant_any) begin
                rr_ptr <= rr_next;
                if (grant_writable) begin
                    bus.wb_rd   <= grant_rd;
                    bus.wb_data <= grant_data;
                end else begin
                    wb_err <= 1'b1;
                end
            end
        end else begin
            bus.wb_valid <= 1'b0;
        end
    end

    // Stall and idle indications derived from current state
    assign hazard = busy[chk_rs] | busy[chk_rt] | busy[chk_rd];
    assign idle   = (busy == 16'h0000) && !bus.wb_valid;
endmodule

// File: tb/tb_writeback_arbiter.sv
// tb/tb_writeback_arbiter.sv - scoreboard bench for writeback_arbiter
module tb_writeback_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        issue_valid;
    logic [3:0]  issue_rd, chk_rs, chk_rt, chk_rd;
    logic        hazard, idle, wb_err;
    logic [15:0] busy;

    writeback_arbiter_if #(.NUM_SRC(4), .DATA_BITS(16)) bus ();

    writeback_arbiter #(.NUM_SRC(4), .DATA_BITS(16), .NUM_FREE(13)) dut (
        .clk(clk), .reset(reset), .enable(enable), .bus(bus),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .chk_rs(chk_rs), .chk_rt(chk_rt), .chk_rd(chk_rd),
        .hazard(hazard), .busy(busy), .idle(idle), .wb_err(wb_err)
    );

    always #5 clk = ~clk;

    typedef struct { logic [3:0] rd; logic [15:0] data; } wb_t;
    wb_t sb[$];

    int          errors = 0;
    int          checks = 0;
    int          m_rr;
    logic [15:0] m_busy;
    logic        m_err;
    int          last_g;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic set_src(input int i, input logic [3:0] rd, input logic [15:0] d);
        bus.src_valid[i]     = 1'b1;
        bus.src_rd[4*i +: 4] = rd;
        bus.src_data[16*i +: 16] = d;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.src_valid = '0;
        issue_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        m_rr = 0; m_busy = '0; m_err = 1'b0;
        sb.delete();
        check_eq("rst_wb_valid", bus.wb_valid, 0);
        check_eq("rst_wb_rd", bus.wb_rd, 0);
        check_eq("rst_wb_data", bus.wb_data, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_wb_err", wb_err, 0);
        check_eq("rst_idle", idle, 1);
        check_eq("rst_src_ready", bus.src_ready, 0);
        check_eq("rst_hazard", hazard, 0);
    endtask

    // One clock: predict grant and scoreboard, advance, then compare outputs
    task automatic cycle();
        int          g;
        logic [3:0]  rd;
        logic [15:0] nb;
        logic        exp_wv;
        wb_t         it;
        #1;
        g = -1;
        if (enable)
            for (int k = 0; k < 4; k++)
                if (g < 0 && bus.src_valid[(m_rr + k) % 4]) g = (m_rr + k) % 4;
        check_eq("src_ready", bus.src_ready, (g >= 0) ? (32'd1 << g) : 32'd0);
        check_eq("hazard_pre", hazard, m_busy[chk_rs] | m_busy[chk_rt] | m_busy[chk_rd]);
        nb = m_busy;
        exp_wv = 1'b0;
        if (g >= 0) begin
            rd = bus.src_rd[4*g +: 4];
            if (rd < 13) begin
                nb[rd] = 1'b0;
                exp_wv = 1'b1;
                it.rd = rd;
                it.data = bus.src_data[16*g +: 16];
                sb.push_back(it);
            end else begin
                m_err = 1'b1;
            end
            m_rr = (g + 1) % 4;
        end
        if (enable && issue_valid && issue_rd < 13) nb[issue_rd] = 1'b1;
        last_g = g;
        @(posedge clk); #1;
        if (enable) m_busy = nb;
        check_eq("wb_valid", bus.wb_valid, exp_wv);
        if (bus.wb_valid) begin
            if (sb.size() == 0) begin
                check_eq("sb_empty", 1, 0);
            end else begin
                it = sb.pop_front();
                check_eq("wb_rd", bus.wb_rd, it.rd);
                check_eq("wb_data", bus.wb_data, it.data);
            end
        end
        check_eq("busy", busy, m_busy);
        check_eq("wb_err", wb_err, m_err);
        check_eq("idle", idle, (m_busy == 0) && !exp_wv);
        check_eq("hazard_post", hazard, m_busy[chk_rs] | m_busy[chk_rt] | m_busy[chk_rd]);
        if (g >= 0) bus.src_valid[g] = 1'b0;
        issue_valid = 1'b0;
    endtask

    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        enable = 1'b1;
        bus.src_valid = '0; bus.src_rd = '0; bus.src_data = '0;
        issue_valid = 1'b0; issue_rd = '0;
        chk_rs = 4'd0; chk_rt = 4'd0; chk_rd = 4'd0;
        do_reset();

        // All sources valid, rd 1..4: grants 0,1,2,3 in order
        for (int i = 0; i < 4; i++) set_src(i, 4'(i + 1), 16'h1111 * 16'(i + 1));
        for (int i = 0; i < 4; i++) begin
            cycle();
            check_eq("t1_grant", last_g, i);
            check_eq("t1_wb_rd", bus.wb_rd, i + 1);
        end
        cycle();

        // Bring rr_ptr to 2, then src0 and src3 contend: src3 first
        set_src(1, 4'd8, 16'hBEEF);
        cycle();
        set_src(0, 4'd9, 16'h0A0A);
        set_src(3, 4'd10, 16'h3C3C);
        cycle();
        check_eq("rr_first", last_g, 3);
        cycle();
        check_eq("rr_second", last_g, 0);

        // Issue rd=5, stalled reader, LSU completes
        issue_valid = 1'b1; issue_rd = 4'd5;
        cycle();
        chk_rs = 4'd5;
        #1 check_eq("t3_hazard_set", hazard, 1);
        set_src(1, 4'd5, 16'h4000);
        cycle();
        check_eq("t3_wb_data", bus.wb_data, 16'h4000);
        check_eq("t3_hazard_clr", hazard, 0);
        check_eq("t3_busy5", busy[5], 0);
        chk_rs = 4'd0;

        // Same-edge issue and FMA completion on rd=7: set wins
        issue_valid = 1'b1; issue_rd = 4'd7;
        set_src(2, 4'd7, 16'h7777);
        cycle();
        check_eq("t4_busy7", busy[7], 1);
        check_eq("t4_wb_rd", bus.wb_rd, 7);

        // Write to read-only register, issue to read-only register
        set_src(0, 4'd14, 16'hDEAD);
        cycle();
        check_eq("t5_grant", last_g, 0);
        check_eq("t5_wb_valid", bus.wb_valid, 0);
        check_eq("t5_wb_err", wb_err, 1);
        issue_valid = 1'b1; issue_rd = 4'd15;
        cycle();
        check_eq("t5_busy", busy, 16'h0080);
        check_eq("t5_err_sticky", wb_err, 1);

        // Thread disabled: no grant, no issue
        enable = 1'b0;
        set_src(3, 4'd3, 16'h0033);
        issue_valid = 1'b1; issue_rd = 4'd2;
        cycle();
        check_eq("t7_busy_held", busy, 16'h0080);
        enable = 1'b1;
        cycle();

        // Reset mid-operation with busy=0006 and wb_valid=1
        do_reset();
        issue_valid = 1'b1; issue_rd = 4'd1;
        cycle();
        issue_valid = 1'b1; issue_rd = 4'd2;
        cycle();
        set_src(2, 4'd3, 16'h5A5A);
        cycle();
        check_eq("t6_busy", busy, 16'h0006);
        check_eq("t6_wb_valid", bus.wb_valid, 1);
        do_reset();
        for (int i = 0; i < 4; i++) set_src(i, 4'(i + 1), 16'h0100 + 16'(i));
        cycle();
        check_eq("t6_rr_zero", last_g, 0);
        bus.src_valid = '0;
        cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
